btn_updown_counter: RTL and testbench
=====================================

BTN_UPDOWN_COUNTER -- requirements
Module: btn_updown_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter and LED width, in bits; legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16: number of consecutive stable samples needed to accept a button level change; legal range >=1.
REQ-003 Parameter WRAP, default 1: 1 = modular wrap-around, 0 = saturate at 0 and 2^WIDTH-1.
REQ-004 clk_i  input  1  single clock, all logic on rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 btn_n_i  input  3  active-low raw buttons, asynchronous to clk_i: [0]=up, [1]=down, [2]=clear.
REQ-007 led_n_o  output  WIDTH  active-low count display, always equal to ~count_o.
REQ-008 count_o  output  WIDTH  current counter value, active-high.
REQ-009 limit_o  output  1  one-cycle pulse when an accepted up/down press wraps or is blocked by saturation.

Function
REQ-010 Each button channel SHALL invert btn_n_i, then pass it through a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL hold a debounced state and a stability counter wide enough for DEBOUNCE_CYCLES.
REQ-012 Stability counter: SHALL clear whenever the synchronized level equals the debounced state, or when the synchronized level changes.
REQ-013 Stability counter: SHALL otherwise increment by 1 per cycle.
REQ-014 The debounced state SHALL take the synchronized level on the edge where the stability counter reaches DEBOUNCE_CYCLES-1 while still counting, and the stability counter SHALL clear on that edge.
REQ-015 A press event SHALL be a 0->1 transition of a debounced state; 1->0 transitions and held levels SHALL generate no events.
REQ-016 The count SHALL change exactly DEBOUNCE_CYCLES+3 rising edges after the first edge on which a stable asserted raw level is sampled (2 synchronizer edges, DEBOUNCE_CYCLES debounce edges, 1 count-update edge).
REQ-017 Event priority in one cycle SHALL be: clear > (up and down together) > up > down.
REQ-018 A clear event SHALL set count_o to 0 and SHALL NOT pulse limit_o.
REQ-019 Simultaneous up and down events SHALL leave count_o unchanged and SHALL NOT pulse limit_o.
REQ-020 Up with WRAP=1 at 2^WIDTH-1 SHALL give 0; down with WRAP=1 at 0 SHALL give 2^WIDTH-1; limit_o SHALL pulse for one cycle in both cases.
REQ-021 Up with WRAP=0 at 2^WIDTH-1, or down with WRAP=0 at 0, SHALL leave count_o unchanged and SHALL pulse limit_o for one cycle.
REQ-022 All other up/down events SHALL change count_o by exactly +1 or -1.
REQ-023 limit_o SHALL be registered and asserted in the same cycle that count_o shows the result of the event.
REQ-024 Holding a button for any duration SHALL produce exactly one event; a bounce shorter than DEBOUNCE_CYCLES cycles SHALL produce none.
REQ-025 A release followed by a re-press SHALL produce a new event only after the release is itself debounced.

Reset
REQ-026 While rst_i is high, regardless of clock, the block SHALL hold: count_o=0, led_n_o all ones, limit_o=0, all synchronizer flops=0, all debounced states=0, all stability counters=0.
REQ-027 Assertion of rst_i mid-debounce or mid-press SHALL discard all partial progress.
REQ-028 After rst_i deasserts, a button already held low SHALL count as a new press after DEBOUNCE_CYCLES+3 edges.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-029 Bench SHALL check single press: btn_n_i[0] low for 20 cycles from reset -> count_o 0->1 exactly 7 edges after first low sample, stays 1 while held, led_n_o=4'b1110.
REQ-030 Bench SHALL check bounce: btn_n_i[0] toggling with 2-cycle pulses, then released -> count_o stays 0, limit_o never asserted.
REQ-031 Bench SHALL check wrap: WRAP=1, 16 up presses from 0 -> count_o returns to 0 and limit_o pulses once on the 16th press; one down press from 0 -> 15 with a limit_o pulse.
REQ-032 Bench SHALL check saturation: WRAP=0, 17 up presses -> count_o=15, limit_o pulses only on the 16th and 17th presses; 16 down presses -> 0, then 1 more press -> stays 0 with a limit_o pulse.
REQ-033 Bench SHALL check simultaneous events: up and down pressed on the same cycle at count 5 -> stays 5; up, down and clear pressed together -> 0.
REQ-034 Bench SHALL check reset mid-operation: rst_i pulsed 3 cycles after up is asserted, at count 9 -> count_o=0 immediately (asynchronously), then held up yields 1 exactly 7 edges after reset release.

Source files
------------

// File: rtl/btn_updown_counter.sv
// -----------------------------------------------------------------------------
// btn_updown_counter
//
// Up/down counter driven by three raw, bouncing, active-low push buttons.
// Each button is synchronized (2 flops), debounced with a per-channel
// stability counter, and edge-detected so that one physical press produces
// exactly one event. Events update a WIDTH-bit counter that either wraps or
// saturates at its limits; hitting a limit raises a one-cycle limit pulse.
//
// Ports
//   clk_i    in   1      single clock, rising edge
//   rst_i    in   1      asynchronous, active-high reset
//   btn_n_i  in   3      raw active-low buttons: [0]=up, [1]=down, [2]=clear
//   led_n_o  out  WIDTH  active-low copy of the count (always ~count_o)
//   count_o  out  WIDTH  current count
//   limit_o  out  1      pulse when an up/down event wraps or is blocked
// -----------------------------------------------------------------------------
module btn_updown_counter #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit WRAP            = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       btn_n_i,
  output logic [WIDTH-1:0] led_n_o,
  output logic [WIDTH-1:0] count_o,
  output logic             limit_o
);

  // Stability counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]    STAB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    STAB_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]    STAB_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);

  logic [2:0]         sync_meta;
  logic [2:0]         sync_lvl;
  logic [2:0]         deb;
  logic [2:0]         deb_prev;
  logic [2:0]         deb_next;
  logic [2:0][CW-1:0] stab;
  logic [2:0][CW-1:0] stab_next;
  logic [2:0]         press;
  logic [WIDTH-1:0]   count_next;
  logic               limit_next;

  // A press is the rising edge of the debounced level only.
  assign press = deb & ~deb_prev;

  // Debounce: count consecutive cycles the synchronized level disagrees with
  // the accepted state. Because the level is one bit, any change of the
  // synchronized level while counting makes it agree again, which clears
  // the counter through the first branch.
  always_comb begin
    deb_next  = deb;
    stab_next = stab;
    for (int ch = 0; ch < 3; ch++) begin
      if (sync_lvl[ch] == deb[ch]) begin
        stab_next[ch] = STAB_ZERO;
      end else if (stab[ch] == STAB_LAST) begin
        deb_next[ch]  = sync_lvl[ch];
        stab_next[ch] = STAB_ZERO;
      end else begin
        stab_next[ch] = stab[ch] + STAB_ONE;
      end
    end
  end

  // Counter update with priority clear > (up and down) > up > down.
  always_comb begin
    count_next = count_o;
    limit_next = 1'b0;
    if (press[2]) begin
      count_next = COUNT_ZERO;
    end else if (press[0] && press[1]) begin
      count_next = count_o;
    end else if (press[0]) begin
      if (count_o == COUNT_MAX) begin
        limit_next = 1'b1;
        if (WRAP) begin
          count_next = COUNT_ZERO;
        end else begin
          count_next = COUNT_MAX;
        end
      end else begin
        count_next = count_o + COUNT_ONE;
      end
    end else if (press[1]) begin
      if (count_o == COUNT_ZERO) begin
        limit_next = 1'b1;
        if (WRAP) begin
          count_next = COUNT_MAX;
        end else begin
          count_next = COUNT_ZERO;
        end
      end else begin
        count_next = count_o - COUNT_ONE;
      end
    end else begin
      count_next = count_o;
    end
  end

  // Input synchronizers and debounce state; buttons are inverted on entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_meta <= 3'b000;
      sync_lvl  <= 3'b000;
      deb       <= 3'b000;
      deb_prev  <= 3'b000;
      stab      <= {3{STAB_ZERO}};
    end else begin
      sync_meta <= ~btn_n_i;
      sync_lvl  <= sync_meta;
      deb       <= deb_next;
      deb_prev  <= deb;
      stab      <= stab_next;
    end
  end

  // Registered outputs; the LED image is registered alongside the count so
  // the two can never disagree.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= COUNT_ZERO;
      led_n_o <= COUNT_MAX;
      limit_o <= 1'b0;
    end else begin
      count_o <= count_next;
      led_n_o <= ~count_next;
      limit_o <= limit_next;
    end
  end

endmodule

// File: tb/tb_btn_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_btn_updown_counter
//
// Drives two counters (WRAP=1 and WRAP=0, WIDTH=4, DEBOUNCE_CYCLES=4) from the
// same button stimulus. A reference model accepts a button level once the
// last DEBOUNCE_CYCLES synchronized samples all agree on it, and pushes each
// visible counter change (cycle, value, limit) into a per-DUT queue. A
// monitor pops and compares whenever a DUT shows a count change or a limit
// pulse. Directed sequences cover the listed scenarios, followed by random
// button patterns.
// -----------------------------------------------------------------------------
module tb_btn_updown_counter;

  localparam int W = 4;
  localparam int D = 4;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
    logic       lim;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   btn_n = 3'b111;
  logic [W-1:0] led_w, cnt_w, led_s, cnt_s;
  logic         lim_w, lim_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t q_w[$];
  exp_t q_s[$];

  logic [2:0] hist [D+2];
  logic [2:0] m_deb = 3'b000;
  logic [2:0] m_press;
  int         m_cnt_w = 0;
  int         m_cnt_s = 0;
  int         ones;
  int         nv;
  bit         nlim;

  logic [W-1:0] prev_w = '0;
  logic [W-1:0] prev_s = '0;
  int           lim_w_total = 0;
  int           lim_s_total = 0;
  exp_t         e;
  logic [3:0]   nled;

  btn_updown_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .WRAP(1'b1)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .btn_n_i(btn_n),
    .led_n_o(led_w), .count_o(cnt_w), .limit_o(lim_w)
  );

  btn_updown_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .WRAP(1'b0)) dut_sat (
    .clk_i(clk), .rst_i(rst), .btn_n_i(btn_n),
    .led_n_o(led_s), .count_o(cnt_s), .limit_o(lim_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input int got);
    checks++;
    errors++;
    $display("FAIL %s: got %0d, expected none", name, got);
  endtask

  // Counter rule from plain arithmetic: clear, cancel, +1/-1 with limits.
  function automatic int step_count(input int c, input logic [2:0] p, input bit wrap, output bit lim);
    int v;
    v = c;
    lim = 1'b0;
    if (p[2]) v = 0;
    else if (p[0] && p[1]) v = c;
    else if (p[0]) begin
      v = c + 1;
      if (v > 15) begin lim = 1'b1; v = wrap ? 0 : 15; end
    end else if (p[1]) begin
      v = c - 1;
      if (v < 0) begin lim = 1'b1; v = wrap ? 15 : 0; end
    end
    return v;
  endfunction

  // Reference model: hist[0] is the level sampled at this edge; the
  // debouncer sees it two edges later, so hist[2..D+1] are the last D
  // samples it has judged.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < D + 2; i++) hist[i] = 3'b000;
      m_deb   = 3'b000;
      m_cnt_w = 0;
      m_cnt_s = 0;
      q_w.delete();
      q_s.delete();
    end else begin
      for (int i = D + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ~btn_n;
      m_press = 3'b000;
      for (int ch = 0; ch < 3; ch++) begin
        ones = 0;
        for (int k = 2; k <= D + 1; k++) if (hist[k][ch]) ones++;
        if (!m_deb[ch] && ones == D) begin
          m_deb[ch]   = 1'b1;
          m_press[ch] = 1'b1;
        end else if (m_deb[ch] && ones == 0) begin
          m_deb[ch] = 1'b0;
        end
      end
      if (m_press != 3'b000) begin
        nv = step_count(m_cnt_w, m_press, 1'b1, nlim);
        if (nv != m_cnt_w || nlim) q_w.push_back('{cyc + 1, 4'(nv), nlim});
        m_cnt_w = nv;
        nv = step_count(m_cnt_s, m_press, 1'b0, nlim);
        if (nv != m_cnt_s || nlim) q_s.push_back('{cyc + 1, 4'(nv), nlim});
        m_cnt_s = nv;
      end
    end
  end

  // Monitor: any count change or limit pulse must match the queue head.
  always @(negedge clk) begin
    if (rst) begin
      prev_w = '0;
      prev_s = '0;
    end else begin
      if (cnt_w !== prev_w || lim_w === 1'b1) begin
        if (lim_w === 1'b1) lim_w_total++;
        if (q_w.size() > 0) begin
          e = q_w.pop_front();
          nled = ~e.cnt;
          check("wrap_count", cnt_w, e.cnt);
          check("wrap_limit", lim_w, e.lim);
          check("wrap_cycle", cyc, e.cyc);
          check("wrap_led", led_w, nled);
        end else flag("wrap_unexpected_event", cnt_w);
      end else if (q_w.size() > 0 && q_w[0].cyc < cyc) begin
        e = q_w.pop_front();
        flag("wrap_missed_event", e.cnt);
      end
      if (cnt_s !== prev_s || lim_s === 1'b1) begin
        if (lim_s === 1'b1) lim_s_total++;
        if (q_s.size() > 0) begin
          e = q_s.pop_front();
          nled = ~e.cnt;
          check("sat_count", cnt_s, e.cnt);
          check("sat_limit", lim_s, e.lim);
          check("sat_cycle", cyc, e.cyc);
          check("sat_led", led_s, nled);
        end else flag("sat_unexpected_event", cnt_s);
      end else if (q_s.size() > 0 && q_s[0].cyc < cyc) begin
        e = q_s.pop_front();
        flag("sat_missed_event", e.cnt);
      end
      prev_w = cnt_w;
      prev_s = cnt_s;
    end
  end

  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    btn_n = ~mask;
    repeat (8) @(negedge clk);
    btn_n = 3'b111;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Call right after a button is driven at a negedge: the next rising edge
  // is the first sampling edge and counts as edge 1 of the latency.
  task automatic measure_latency(input string name);
    int start;
    int got;
    logic [W-1:0] c0;
    start = cyc + 1;
    got = -1;
    c0 = cnt_w;
    for (int i = 0; i < 30 && got < 0; i++) begin
      @(negedge clk);
      if (cnt_w !== c0) got = cyc - start + 1;
    end
    check(name, got, D + 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lw0, ls0;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_count_w", cnt_w, 4'd0);
    check("reset_count_s", cnt_s, 4'd0);
    check("reset_led_w", led_w, 4'b1111);
    check("reset_limit_w", lim_w, 1'b0);
    check("reset_limit_s", lim_s, 1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Bounce: 2-cycle pulses on up never settle long enough
    lw0 = lim_w_total; ls0 = lim_s_total;
    for (int i = 0; i < 8; i++) begin
      btn_n = 3'b110;
      repeat (2) @(negedge clk);
      btn_n = 3'b111;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("bounce_count", cnt_w, 4'd0);
    check("bounce_limits", lim_w_total - lw0 + lim_s_total - ls0, 0);

    // Single press held 20 cycles from reset
    do_reset();
    btn_n = 3'b110;
    measure_latency("single_press_latency");
    check("single_press_count", cnt_w, 4'd1);
    check("single_press_led", led_w, 4'b1110);
    repeat (13) @(negedge clk);
    check("held_no_repeat", cnt_w, 4'd1);
    btn_n = 3'b111;
    repeat (10) @(negedge clk);

    // Wrap / saturation going up
    press(3'b100);
    lw0 = lim_w_total; ls0 = lim_s_total;
    repeat (16) press(3'b001);
    check("wrap16_count", cnt_w, 4'd0);
    check("wrap16_limits", lim_w_total - lw0, 1);
    check("sat16_count", cnt_s, 4'd15);
    check("sat16_limits", lim_s_total - ls0, 1);
    press(3'b001);
    check("sat17_count", cnt_s, 4'd15);
    check("sat17_limits", lim_s_total - ls0, 2);
    check("wrap17_count", cnt_w, 4'd1);

    // Saturation going down
    repeat (16) press(3'b010);
    check("sat_down16_count", cnt_s, 4'd0);
    ls0 = lim_s_total;
    press(3'b010);
    check("sat_down17_count", cnt_s, 4'd0);
    check("sat_down17_limit", lim_s_total - ls0, 1);

    // Wrap going down from 0
    press(3'b100);
    lw0 = lim_w_total;
    press(3'b010);
    check("wrap_down_count", cnt_w, 4'd15);
    check("wrap_down_limit", lim_w_total - lw0, 1);

    // Simultaneous events
    press(3'b100);
    repeat (5) press(3'b001);
    lw0 = lim_w_total; ls0 = lim_s_total;
    press(3'b011);
    check("updown_count_w", cnt_w, 4'd5);
    check("updown_count_s", cnt_s, 4'd5);
    check("updown_limits", lim_w_total - lw0 + lim_s_total - ls0, 0);
    press(3'b111);
    check("all3_count_w", cnt_w, 4'd0);
    check("all3_count_s", cnt_s, 4'd0);

    // Reset while up is being debounced at count 9
    press(3'b100);
    repeat (9) press(3'b001);
    check("pre_reset_count", cnt_w, 4'd9);
    @(negedge clk);
    btn_n = 3'b110;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_count_w", cnt_w, 4'd0);
    check("async_reset_count_s", cnt_s, 4'd0);
    check("async_reset_led_s", led_s, 4'b1111);
    check("async_reset_limit", lim_w, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    measure_latency("reset_release_latency");
    check("reset_release_count", cnt_s, 4'd1);
    btn_n = 3'b111;
    repeat (10) @(negedge clk);

    // Random button patterns against the model
    for (int i = 0; i < 60; i++) begin
      btn_n = ~3'($urandom_range(0, 7));
      repeat ($urandom_range(1, 12)) @(negedge clk);
    end
    btn_n = 3'b111;
    repeat (14) @(negedge clk);
    check("final_count_w", cnt_w, 4'(m_cnt_w));
    check("final_count_s", cnt_s, 4'(m_cnt_s));
    check("queue_drained_w", q_w.size(), 0);
    check("queue_drained_s", q_s.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
